hamming_uart_frame_rx: RTL and testbench

Receive-side counterpart of the Hamming(7,4) UART transmit path. The transmit path sends 8N1 frames whose byte is `{1'b0, code[6:0]}`. This block sits on the RX pin, oversamples the line and deserializes each frame. It corrects any single-bit error in the 7-bit code and presents the recovered nibble with valid, syndrome, correction and framing-error status.

---
 rtl/hamming_uart_frame_rx.sv | 158 +++++++++++++++
 tb/tb_hamming_uart_frame_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_uart_frame_rx.sv
// Oversampling 8N1 receiver that recovers a Hamming(7,4) nibble from each frame.
// Corrects single-bit errors and reports syndrome/correction, valid and framing-error pulses.
module hamming_uart_frame_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  output logic [3:0] data_out,
  output logic [2:0] syndrome_out,
  output logic       corrected_out,
  output logic       valid_out,
  output logic       frame_err_out,
  output logic       busy_out,
  output logic [1:0] state_out
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rxs, armed;
  logic [CW-1:0] cnt;
  logic [2:0]    bitidx;
  logic [7:0]    shreg;
  logic          pend_vld, pend_err;
  logic [6:0]    pend_code;
  logic          half_tick, bit_tick, stop_ok;
  logic [2:0]    syn;
  logic [6:0]    fixed_code;

  assign half_tick = (cnt == CW'(CLKS_PER_BIT / 2 - 1));
  assign bit_tick  = (cnt == CW'(CLKS_PER_BIT - 1));
  assign stop_ok   = rxs && !shreg[7];

  // Both flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!ena) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (armed && !rxs) state_nxt = START;
        START: if (half_tick) state_nxt = rxs ? IDLE : DATA;
        DATA:  if (bit_tick && bitidx == 3'd7) state_nxt = STOP;
        STOP:  if (bit_tick) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_out  = (state != IDLE);
    state_out = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      cnt       <= '0;
      bitidx    <= '0;
      shreg     <= '0;
      pend_vld  <= 1'b0;
      pend_err  <= 1'b0;
      pend_code <= '0;
    end else begin
      pend_vld <= 1'b0;
      pend_err <= 1'b0;
      if (!ena) begin
        armed  <= 1'b0;
        cnt    <= '0;
        bitidx <= '0;
      end else begin
        case (state)
          IDLE: begin
            // Armed only after the line has been seen high; cleared as a start is taken.
            armed  <= rxs;
            cnt    <= '0;
            bitidx <= '0;
          end
          START: begin
            cnt    <= half_tick ? '0 : cnt + 1'b1;
            bitidx <= '0;
          end
          DATA: begin
            if (bit_tick) begin
              shreg[bitidx] <= rxs;
              cnt           <= '0;
              bitidx        <= bitidx + 3'd1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP: begin
            if (bit_tick) begin
              cnt       <= '0;
              pend_vld  <= stop_ok;
              pend_err  <= !stop_ok;
              pend_code <= shreg[6:0];
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

  always_comb begin
    syn[0]     = pend_code[0] ^ pend_code[2] ^ pend_code[4] ^ pend_code[6];
    syn[1]     = pend_code[1] ^ pend_code[2] ^ pend_code[5] ^ pend_code[6];
    syn[2]     = pend_code[3] ^ pend_code[4] ^ pend_code[5] ^ pend_code[6];
    fixed_code = pend_code;
    if (syn != 3'd0) fixed_code = pend_code ^ (7'b1 << (syn - 3'd1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out      <= '0;
      syndrome_out  <= '0;
      corrected_out <= 1'b0;
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      valid_out     <= pend_vld && ena;
      frame_err_out <= pend_err && ena;
      if (pend_vld && ena) begin
        data_out      <= {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
        syndrome_out  <= syn;
        corrected_out <= (syn != 3'd0);
      end
    end
  end

endmodule

// File: tb/tb_hamming_uart_frame_rx.sv
// Bench for hamming_uart_frame_rx: directed frames plus random frames against a
// position-XOR Hamming model.
module tb_hamming_uart_frame_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n, ena, rx;
  logic [3:0] data_out;
  logic [2:0] syndrome_out;
  logic       corrected_out, valid_out, frame_err_out, busy_out;
  logic [1:0] state_out;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  int         vcnt = 0;
  int         ecnt = 0;
  bit         both = 1'b0;
  logic [7:0] vq[$];

  always #5 clk = ~clk;

  hamming_uart_frame_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx),
    .data_out(data_out), .syndrome_out(syndrome_out), .corrected_out(corrected_out),
    .valid_out(valid_out), .frame_err_out(frame_err_out),
    .busy_out(busy_out), .state_out(state_out)
  );

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      vcnt++;
      vq.push_back({corrected_out, syndrome_out, data_out});
    end
    if (frame_err_out === 1'b1) ecnt++;
    if (valid_out === 1'b1 && frame_err_out === 1'b1) both = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_next(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = 8'hxx;
    if (vq.size() > 0) got = vq.pop_front();
    check(tag, 32'(got), 32'(exp));
  endtask

  // Hold rx at v for n clocks; always returns 1 time unit after a rising edge.
  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(stop, CPB);
  endtask

  // Start bit, bits 0..2, then half of bit 3: the receiver is mid bit 3.
  task automatic send_partial(input logic [7:0] b);
    drive(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive(b[i], CPB);
    drive(b[3], CPB / 2);
  endtask

  // Parity bits chosen so that the XOR of the positions of all set bits is zero.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] c;
    int s;
    c = '0;
    s = 0;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    for (int p = 1; p <= 7; p++) if (c[p-1]) s = s ^ p;
    c[0] = s[0]; c[1] = s[1]; c[3] = s[2];
    return c;
  endfunction

  // Returns {corrected, syndrome, nibble}; syndrome = XOR of positions of set bits.
  function automatic logic [7:0] ref_dec(input logic [6:0] code);
    logic [6:0] c;
    int s;
    c = code;
    s = 0;
    for (int p = 1; p <= 7; p++) if (c[p-1]) s = s ^ p;
    if (s != 0) c[s-1] = ~c[s-1];
    return {(s != 0), 3'(s), c[6], c[5], c[4], c[2]};
  endfunction

  initial begin
    int v0, e0, mode, p1, p2;
    logic [3:0] d;
    logic [6:0] code;
    logic [7:0] held, r;
    logic pad, stop;

    rst_n = 1'b0; ena = 1'b1; rx = 1'b1;
    #3;
    check("rst_data", 32'(data_out), 0);
    check("rst_syn", 32'(syndrome_out), 0);
    check("rst_corr", 32'(corrected_out), 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_ferr", 32'(frame_err_out), 0);
    check("rst_busy", 32'(busy_out), 0);
    check("rst_state", 32'(state_out), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 20);

    // Clean frame
    vq.delete(); v0 = vcnt;
    send_frame(8'h52, 1'b1); drive(1'b1, 8);
    check("clean_cnt", 32'(vcnt - v0), 1);
    check_next("clean_val", 8'h0A);

    // Single-bit error in code[4]
    v0 = vcnt;
    send_frame(8'h42, 1'b1); drive(1'b1, 8);
    check("sbe_cnt", 32'(vcnt - v0), 1);
    check_next("sbe_val", {1'b1, 3'd5, 4'hA});

    // Back-to-back
    v0 = vcnt;
    send_frame(8'h00, 1'b1); send_frame(8'h7F, 1'b1); send_frame(8'h52, 1'b1);
    drive(1'b1, 8);
    check("b2b_cnt", 32'(vcnt - v0), 3);
    check_next("b2b_0", 8'h00);
    check_next("b2b_1", 8'h0F);
    check_next("b2b_2", 8'h0A);

    // Framing error, then a frame with no high line in between
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h00, 1'b0);
    drive(1'b0, 10 * CPB);
    check("ferr_cnt", 32'(ecnt - e0), 1);
    check("ferr_noval", 32'(vcnt - v0), 0);
    check("ferr_hold", 32'(data_out), 32'h A);
    check("ferr_state", 32'(state_out), 0);
    drive(1'b1, CPB);
    send_frame(8'h52, 1'b1); drive(1'b1, 8);
    check("ferr_rec_cnt", 32'(vcnt - v0), 1);
    check_next("ferr_rec_val", 8'h0A);

    // False start: 5-clk glitch; also start-detect latency
    v0 = vcnt; e0 = ecnt;
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("lat_2clk", 32'(state_out), 0);
    @(posedge clk);
    #1 check("lat_3clk", 32'(state_out), 1);
    check("fs_busy_hi", 32'(busy_out), 1);
    repeat (2) @(posedge clk);
    #1 rx = 1'b1;
    repeat (7) @(posedge clk);
    #1 check("fs_state", 32'(state_out), 0);
    check("fs_busy_lo", 32'(busy_out), 0);
    drive(1'b1, 2 * CPB);
    check("fs_nopulse", 32'((vcnt - v0) + (ecnt - e0)), 0);

    // Load nonzero status, then async reset mid DATA bit 3
    send_frame(8'h42, 1'b1); drive(1'b1, 8);
    check_next("pre_rst_val", {1'b1, 3'd5, 4'hA});
    send_partial(8'h52);
    check("abort_in_data", 32'(state_out), 2);
    rst_n = 1'b0;
    #1;
    check("arst_data", 32'(data_out), 0);
    check("arst_syn", 32'(syndrome_out), 0);
    check("arst_corr", 32'(corrected_out), 0);
    check("arst_state", 32'(state_out), 0);
    check("arst_busy", 32'(busy_out), 0);
    rx = 1'b1;
    drive(1'b1, 4);
    rst_n = 1'b1;
    drive(1'b1, 20);

    // Random good frame, then abort with ena=0
    d = 4'($urandom_range(15));
    vq.delete(); v0 = vcnt;
    send_frame({1'b0, enc(d)}, 1'b1); drive(1'b1, 8);
    check("post_rst_cnt", 32'(vcnt - v0), 1);
    check_next("post_rst_val", {4'h0, d});
    v0 = vcnt; e0 = ecnt;
    send_partial(8'h52);
    check("ena_in_data", 32'(state_out), 2);
    ena = 1'b0;
    @(posedge clk);
    #1 check("ena_state", 32'(state_out), 0);
    check("ena_busy", 32'(busy_out), 0);
    drive(1'b1, 3 * CPB);
    ena = 1'b1;
    drive(1'b1, 12 * CPB);
    check("ena_nopulse", 32'((vcnt - v0) + (ecnt - e0)), 0);
    check("ena_hold", 32'(data_out), 32'(d));

    // Random frames: clean, single flip, double flip, pad set, stop low
    held = {4'h0, d};
    vq.delete();
    for (int k = 0; k < 24; k++) begin
      d = 4'($urandom_range(15));
      mode = int'($urandom_range(4));
      code = enc(d);
      pad = 1'b0;
      stop = 1'b1;
      p1 = int'($urandom_range(6));
      p2 = (p1 + 1 + int'($urandom_range(5))) % 7;
      case (mode)
        1: code[p1] = ~code[p1];
        2: begin code[p1] = ~code[p1]; code[p2] = ~code[p2]; end
        3: pad = 1'b1;
        4: stop = 1'b0;
        default: ;
      endcase
      v0 = vcnt; e0 = ecnt;
      send_frame({pad, code}, stop);
      drive(1'b1, 8);
      if (stop && !pad) begin
        r = ref_dec(code);
        held = r;
        check("rnd_vcnt", 32'(vcnt - v0), 1);
        check("rnd_ecnt", 32'(ecnt - e0), 0);
        check_next("rnd_val", r);
      end else begin
        check("rnd_ferr_vcnt", 32'(vcnt - v0), 0);
        check("rnd_ferr_ecnt", 32'(ecnt - e0), 1);
      end
      check("rnd_held", 32'({corrected_out, syndrome_out, data_out}), 32'(held));
    end

    check("no_overlap", 32'(both), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
